// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one downstream wishbone slave port between the
// I-cache (master 0) and D-cache (master 1) memory-side wishbone masters.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mN_adr/dat_m/sel         master N request fields (N = 0 I-cache, 1 D-cache)
//   mN_cyc/stb/we            master N cycle, strobe, write-enable
//   mN_dat_s/ack/rty         master N response (read data, done, stalled)
//   s_adr/dat_m/sel          downstream request fields
//   s_cyc/stb/we             downstream cycle, strobe, write-enable
//   s_dat_s/ack/rty          downstream response
module cache_arbiter #(
    parameter int ADR_W = 12,
    parameter int DAT_W = 128,
    parameter int SEL_W = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic [ADR_W-1:0] m0_adr,
    input  logic [DAT_W-1:0] m0_dat_m,
    input  logic [SEL_W-1:0] m0_sel,
    input  logic             m0_cyc,
    input  logic             m0_stb,
    input  logic             m0_we,
    output logic [DAT_W-1:0] m0_dat_s,
    output logic             m0_ack,
    output logic             m0_rty,

    input  logic [ADR_W-1:0] m1_adr,
    input  logic [DAT_W-1:0] m1_dat_m,
    input  logic [SEL_W-1:0] m1_sel,
    input  logic             m1_cyc,
    input  logic             m1_stb,
    input  logic             m1_we,
    output logic [DAT_W-1:0] m1_dat_s,
    output logic             m1_ack,
    output logic             m1_rty,

    output logic [ADR_W-1:0] s_adr,
    output logic [DAT_W-1:0] s_dat_m,
    output logic [SEL_W-1:0] s_sel,
    output logic             s_cyc,
    output logic             s_stb,
    output logic             s_we,
    input  logic [DAT_W-1:0] s_dat_s,
    input  logic             s_ack,
    input  logic             s_rty
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state;
    logic   prio;   // 0: master 0 wins a tie, 1: master 1 wins a tie

    logic req0;
    logic req1;
    logic g0;
    logic g1;

    // A granted master simply keeps waiting on a downstream retry.
    logic s_rty_unused;
    assign s_rty_unused = s_rty;

    assign req0 = m0_cyc & m0_stb;
    assign req1 = m1_cyc & m1_stb;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            prio  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req0 && (!req1 || !prio)) begin
                        state <= GRANT0;
                    end else if (req1) begin
                        state <= GRANT1;
                    end
                end
                GRANT0: begin
                    // Abort leaves the tie-break untouched.
                    if (!m0_cyc) begin
                        state <= IDLE;
                    end else if (s_ack) begin
                        state <= IDLE;
                        prio  <= 1'b1;
                    end
                end
                GRANT1: begin
                    if (!m1_cyc) begin
                        state <= IDLE;
                    end else if (s_ack) begin
                        state <= IDLE;
                        prio  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gating with rst drops any in-flight ack during the reset cycle.
    assign g0 = (state == GRANT0) && !rst;
    assign g1 = (state == GRANT1) && !rst;

    assign s_adr   = g0 ? m0_adr   : (g1 ? m1_adr   : '0);
    assign s_dat_m = g0 ? m0_dat_m : (g1 ? m1_dat_m : '0);
    assign s_sel   = g0 ? m0_sel   : (g1 ? m1_sel   : '0);
    assign s_cyc   = (g0 & m0_cyc) | (g1 & m1_cyc);
    assign s_stb   = (g0 & m0_stb) | (g1 & m1_stb);
    assign s_we    = (g0 & m0_we)  | (g1 & m1_we);

    assign m0_dat_s = s_dat_s;
    assign m1_dat_s = s_dat_s;

    assign m0_ack = g0 & s_ack;
    assign m1_ack = g1 & s_ack;

    assign m0_rty = req0 & ~m0_ack;
    assign m1_rty = req1 & ~m1_ack;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed scenarios plus randomized traffic for
// cache_arbiter, checked every cycle against a behavioural model.
module tb_cache_arbiter;

    localparam int ADR_W = 12;
    localparam int DAT_W = 128;
    localparam int SEL_W = 16;

    logic clk = 1'b0;
    logic rst;

    logic [ADR_W-1:0] adr [2];
    logic [DAT_W-1:0] dm  [2];
    logic [SEL_W-1:0] sel [2];
    logic             cyc [2];
    logic             stb [2];
    logic             we  [2];

    logic [DAT_W-1:0] m0_dat_s, m1_dat_s;
    logic             m0_ack, m1_ack, m0_rty, m1_rty;

    logic [ADR_W-1:0] s_adr;
    logic [DAT_W-1:0] s_dat_m;
    logic [SEL_W-1:0] s_sel;
    logic             s_cyc, s_stb, s_we;
    logic [DAT_W-1:0] s_dat_s;
    logic             s_ack, s_rty;

    int n_vec = 0;
    int n_err = 0;

    // Model state: owner of the downstream port (-1 none) and tie winner.
    int owner  = -1;
    int favour = 0;

    always #5 clk = ~clk;

    cache_arbiter #(
        .ADR_W(ADR_W),
        .DAT_W(DAT_W),
        .SEL_W(SEL_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_adr   (adr[0]),
        .m0_dat_m (dm[0]),
        .m0_sel   (sel[0]),
        .m0_cyc   (cyc[0]),
        .m0_stb   (stb[0]),
        .m0_we    (we[0]),
        .m0_dat_s (m0_dat_s),
        .m0_ack   (m0_ack),
        .m0_rty   (m0_rty),
        .m1_adr   (adr[1]),
        .m1_dat_m (dm[1]),
        .m1_sel   (sel[1]),
        .m1_cyc   (cyc[1]),
        .m1_stb   (stb[1]),
        .m1_we    (we[1]),
        .m1_dat_s (m1_dat_s),
        .m1_ack   (m1_ack),
        .m1_rty   (m1_rty),
        .s_adr    (s_adr),
        .s_dat_m  (s_dat_m),
        .s_sel    (s_sel),
        .s_cyc    (s_cyc),
        .s_stb    (s_stb),
        .s_we     (s_we),
        .s_dat_s  (s_dat_s),
        .s_ack    (s_ack),
        .s_rty    (s_rty)
    );

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare every output against the model for the current cycle.
    task automatic probe();
        logic [127:0] e_adr, e_dat, e_sel;
        logic e_cyc, e_stb, e_we;
        logic e_ack [2];
        logic e_rty [2];
        bit granted;
        #4;
        granted = !rst && owner >= 0;
        e_adr = '0; e_dat = '0; e_sel = '0;
        e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
        if (granted) begin
            e_adr = 128'(adr[owner]);
            e_dat = dm[owner];
            e_sel = 128'(sel[owner]);
            e_cyc = cyc[owner];
            e_stb = stb[owner];
            e_we  = we[owner];
        end
        for (int n = 0; n < 2; n++) begin
            e_ack[n] = granted && owner == n && s_ack;
            e_rty[n] = cyc[n] && stb[n] && !e_ack[n];
        end
        chk("s_adr",    128'(s_adr), e_adr);
        chk("s_dat_m",  s_dat_m, e_dat);
        chk("s_sel",    128'(s_sel), e_sel);
        chk("s_cyc",    128'(s_cyc), 128'(e_cyc));
        chk("s_stb",    128'(s_stb), 128'(e_stb));
        chk("s_we",     128'(s_we), 128'(e_we));
        chk("m0_dat_s", m0_dat_s, s_dat_s);
        chk("m1_dat_s", m1_dat_s, s_dat_s);
        chk("m0_ack",   128'(m0_ack), 128'(e_ack[0]));
        chk("m1_ack",   128'(m1_ack), 128'(e_ack[1]));
        chk("m0_rty",   128'(m0_rty), 128'(e_rty[0]));
        chk("m1_rty",   128'(m1_rty), 128'(e_rty[1]));
    endtask

    // Move the model across the clock edge using the inputs just probed.
    task automatic advance();
        int nxt_owner;
        int nxt_favour;
        bit r0, r1;
        r0 = cyc[0] && stb[0];
        r1 = cyc[1] && stb[1];
        nxt_owner  = owner;
        nxt_favour = favour;
        if (rst) begin
            nxt_owner  = -1;
            nxt_favour = 0;
        end else if (owner < 0) begin
            if (r0 && r1) nxt_owner = favour;
            else if (r0)  nxt_owner = 0;
            else if (r1)  nxt_owner = 1;
        end else if (!cyc[owner]) begin
            nxt_owner = -1;
        end else if (s_ack) begin
            nxt_owner  = -1;
            nxt_favour = 1 - owner;
        end
        @(posedge clk);
        owner  = nxt_owner;
        favour = nxt_favour;
        #1;
    endtask

    task automatic set_m(input int n, input logic c, input logic s,
                         input logic w, input logic [ADR_W-1:0] a);
        cyc[n] = c;
        stb[n] = s;
        we[n]  = w;
        adr[n] = a;
        dm[n]  = rnd128();
        sel[n] = SEL_W'($urandom);
    endtask

    initial begin
        logic [127:0] rdat;
        rst = 1'b1;
        s_ack = 1'b0;
        s_rty = 1'b0;
        s_dat_s = rnd128();
        set_m(0, 1'b0, 1'b0, 1'b0, '0);
        set_m(1, 1'b0, 1'b0, 1'b0, '0);

        // Reset state
        probe();
        chk("rst_s_cyc", 128'(s_cyc), 128'(0));
        chk("rst_m0_ack", 128'(m0_ack), 128'(0));
        advance();
        rst = 1'b0;

        // Single master read, slave acks on the third granted cycle
        set_m(0, 1'b1, 1'b1, 1'b0, 12'h123);
        probe();
        chk("single_T_stb", 128'(s_stb), 128'(0));
        chk("single_T_rty", 128'(m0_rty), 128'(1));
        advance();
        for (int i = 1; i <= 3; i++) begin
            if (i == 3) begin
                s_ack = 1'b1;
                rdat = rnd128();
                s_dat_s = rdat;
            end
            probe();
            chk("single_stb", 128'(s_stb), 128'(1));
            chk("single_adr", 128'(s_adr), 128'(12'h123));
            chk("single_ack", 128'(m0_ack), 128'(i == 3));
            if (i == 3) chk("single_dat", m0_dat_s, rdat);
            advance();
        end
        s_ack = 1'b0;
        set_m(0, 1'b0, 1'b0, 1'b0, '0);
        probe();
        chk("single_T4_stb", 128'(s_stb), 128'(0));
        chk("single_T4_ack", 128'(m0_ack), 128'(0));
        advance();

        rst = 1'b1;
        probe();
        advance();
        rst = 1'b0;

        // Simultaneous requests after reset
        set_m(0, 1'b1, 1'b1, 1'b0, 12'h0A0);
        set_m(1, 1'b1, 1'b1, 1'b1, 12'h1B1);
        probe();
        advance();
        s_ack = 1'b1;
        probe();
        chk("sim_g0_adr", 128'(s_adr), 128'(12'h0A0));
        chk("sim_g0_m0ack", 128'(m0_ack), 128'(1));
        chk("sim_g0_m1ack", 128'(m1_ack), 128'(0));
        chk("sim_g0_m1rty", 128'(m1_rty), 128'(1));
        advance();
        s_ack = 1'b0;
        set_m(0, 1'b0, 1'b0, 1'b0, '0);
        probe();
        chk("sim_bubble", 128'(s_cyc), 128'(0));
        advance();
        s_ack = 1'b1;
        probe();
        chk("sim_g1_adr", 128'(s_adr), 128'(12'h1B1));
        chk("sim_g1_we", 128'(s_we), 128'(1));
        chk("sim_g1_ack", 128'(m1_ack), 128'(1));
        advance();
        s_ack = 1'b0;
        set_m(1, 1'b0, 1'b0, 1'b0, '0);

        // Round robin: both keep requesting, slave acks every grant
        set_m(0, 1'b1, 1'b1, 1'b0, 12'h0A0);
        set_m(1, 1'b1, 1'b1, 1'b0, 12'h1B1);
        for (int i = 0; i < 10; i++) begin
            s_ack = 1'(i % 2);
            probe();
            if (i % 2 == 1) begin
                chk("rr_adr", 128'(s_adr),
                    ((i / 2) % 2 == 0) ? 128'(12'h0A0) : 128'(12'h1B1));
                chk("rr_m1ack", 128'(m1_ack), 128'((i / 2) % 2 == 1));
            end else begin
                chk("rr_idle", 128'(s_cyc), 128'(0));
            end
            advance();
        end
        s_ack = 1'b0;

        // Abort by master 1; tie-break currently favours master 1
        set_m(0, 1'b0, 1'b0, 1'b0, '0);
        probe();
        advance();
        probe();
        chk("abort_grant", 128'(s_adr), 128'(12'h1B1));
        advance();
        set_m(1, 1'b0, 1'b0, 1'b0, 12'h1B1);
        probe();
        chk("abort_m1ack", 128'(m1_ack), 128'(0));
        advance();
        s_ack = 1'b1;
        probe();
        chk("stray_m0ack", 128'(m0_ack), 128'(0));
        chk("stray_m1ack", 128'(m1_ack), 128'(0));
        advance();
        s_ack = 1'b0;
        set_m(0, 1'b1, 1'b1, 1'b0, 12'h0A0);
        set_m(1, 1'b1, 1'b1, 1'b0, 12'h1B1);
        probe();
        advance();
        s_ack = 1'b1;
        probe();
        chk("abort_prio", 128'(s_adr), 128'(12'h1B1));
        advance();
        s_ack = 1'b0;
        set_m(0, 1'b0, 1'b0, 1'b0, '0);
        set_m(1, 1'b0, 1'b0, 1'b0, '0);
        probe();
        advance();

        // Reset mid-transfer with a simultaneous downstream ack
        set_m(0, 1'b1, 1'b1, 1'b0, 12'h0C0);
        probe();
        advance();
        probe();
        chk("mid_grant", 128'(s_cyc), 128'(1));
        advance();
        rst = 1'b1;
        s_ack = 1'b1;
        probe();
        chk("mid_rst_ack", 128'(m0_ack), 128'(0));
        advance();
        rst = 1'b0;
        s_ack = 1'b0;
        set_m(0, 1'b0, 1'b0, 1'b0, '0);
        set_m(1, 1'b1, 1'b1, 1'b0, 12'h1D1);
        probe();
        chk("mid_after_cyc", 128'(s_cyc), 128'(0));
        chk("mid_after_ack", 128'(m0_ack), 128'(0));
        advance();
        probe();
        chk("mid_m1_grant", 128'(s_adr), 128'(12'h1D1));
        chk("mid_m1_cyc", 128'(s_cyc), 128'(1));
        advance();

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom % 40) == 0;
            for (int n = 0; n < 2; n++) begin
                cyc[n] = ($urandom % 4) != 0;
                stb[n] = cyc[n] ? (($urandom % 4) != 0) : 1'($urandom % 2);
                we[n]  = 1'($urandom % 2);
                adr[n] = ADR_W'($urandom);
                dm[n]  = rnd128();
                sel[n] = SEL_W'($urandom);
            end
            s_ack   = ($urandom % 3) == 0;
            s_rty   = 1'($urandom % 2);
            s_dat_s = rnd128();
            probe();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
